// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the two requesters, the arbiter and the async FIFO write port.
// master drives requests and the FULL flag; slave is the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int unsigned DataWidth = 8
);
    logic [DataWidth-1:0]   rf_rd_data;
    logic                   rf_rd_vld;
    logic                   rf_ack;
    logic [2*DataWidth-1:0] alu_out;
    logic                   alu_out_vld;
    logic                   alu_ack;
    logic                   fifo_full;
    logic                   w_inc;
    logic [DataWidth-1:0]   wr_data;
    logic                   busy;

    modport master (
        output rf_rd_data, rf_rd_vld, alu_out, alu_out_vld, fifo_full,
        input  rf_ack, alu_ack, w_inc, wr_data, busy
    );

    modport slave (
        input  rf_rd_data, rf_rd_vld, alu_out, alu_out_vld, fifo_full,
        output rf_ack, alu_ack, w_inc, wr_data, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin scheduler sharing the async FIFO write port between the RF and ALU paths.
// Define ALU_WIDE_RESULT_EN to write each ALU result as an atomic LSB-first byte pair.
module fifo_wr_arbiter #(
    parameter int unsigned DataWidth = 8
) (
    input logic            clk,
    input logic            rst_n,
    fifo_wr_arbiter_if.slave bus
);

`ifdef ALU_WIDE_RESULT_EN
    localparam int unsigned HoldWidth = 2 * DataWidth;
    typedef enum logic [1:0] {StIdle, StWrRf, StWrAluLo, StWrAluHi} state_e;
`else
    localparam int unsigned HoldWidth = DataWidth;
    typedef enum logic [1:0] {StIdle, StWrRf, StWrAluLo} state_e;
`endif

    state_e                 state_q, state_d;
    logic                   prio_alu_q, prio_alu_d;
    logic [DataWidth-1:0]   wr_data_q, wr_data_d;
    logic [HoldWidth-1:0]   hold_q, hold_d;
    logic                   rf_grant, alu_grant, w_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            prio_alu_q <= 1'b0;
            wr_data_q  <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            prio_alu_q <= prio_alu_d;
            wr_data_q  <= wr_data_d;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        prio_alu_d = prio_alu_q;
        wr_data_d  = wr_data_q;
        hold_d     = hold_q;
        rf_grant   = 1'b0;
        alu_grant  = 1'b0;
        w_inc      = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A lone requester wins; a tie (both or neither) follows the pointer.
                if (bus.rf_rd_vld != bus.alu_out_vld) begin
                    rf_grant  = bus.rf_rd_vld;
                    alu_grant = bus.alu_out_vld;
                end else begin
                    rf_grant  = ~prio_alu_q;
                    alu_grant = prio_alu_q;
                end
                if (rf_grant && bus.rf_rd_vld) begin
                    wr_data_d  = bus.rf_rd_data;
                    prio_alu_d = 1'b1;
                    state_d    = StWrRf;
                end else if (alu_grant && bus.alu_out_vld) begin
                    hold_d     = bus.alu_out[HoldWidth-1:0];
                    wr_data_d  = bus.alu_out[DataWidth-1:0];
                    prio_alu_d = 1'b0;
                    state_d    = StWrAluLo;
                end
            end
            StWrRf: begin
                w_inc = ~bus.fifo_full;
                if (w_inc) state_d = StIdle;
            end
            StWrAluLo: begin
                w_inc = ~bus.fifo_full;
                if (w_inc) begin
`ifdef ALU_WIDE_RESULT_EN
                    wr_data_d = hold_q[HoldWidth-1:DataWidth];
                    state_d   = StWrAluHi;
`else
                    wr_data_d = hold_q;
                    state_d   = StIdle;
`endif
                end
            end
`ifdef ALU_WIDE_RESULT_EN
            StWrAluHi: begin
                w_inc = ~bus.fifo_full;
                if (w_inc) state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    assign bus.rf_ack  = rf_grant;
    assign bus.alu_ack = alu_grant;
    assign bus.w_inc   = w_inc;
    assign bus.wr_data = wr_data_q;
    assign bus.busy    = (state_q != StIdle);

endmodule
